// File: rtl/ifq_fetch_unit.sv
// ifq_fetch_unit: prefetching fetch front end with a DEPTH-entry instruction queue and redirect/flush.
// Define IFQ_JUMP_PREDECODE_EN to redirect early on the custom unconditional jump (opcode 1100011).
module ifq_fetch_unit #(
    parameter int XLEN = 32,
    parameter int DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                    clk,
    input  logic                    res,
    output logic                    imem_req_o,
    output logic [XLEN-1:0]         imem_addr_o,
    input  logic [31:0]             imem_rdata_i,
    input  logic                    redirect_i,
    input  logic [XLEN-1:0]         redirect_pc_i,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [31:0]             out_inst,
    output logic [XLEN-1:0]         out_pc,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int AW = $clog2(DEPTH);
    logic [XLEN-1:0] fetch_pc, pend_pc, next_pc;
    logic pend, kill, push, pop, jump, unused;
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [31:0] inst_q [DEPTH];
    logic [XLEN-1:0] pc_q [DEPTH];

    // Credit counts the in-flight word so a response always has a free slot.
    assign imem_req_o = res & ~redirect_i & ((AW+2)'(count) + (AW+2)'(pend) < (AW+2)'(DEPTH));
    assign imem_addr_o = fetch_pc;
    assign out_valid = count != '0;
    assign out_inst = out_valid ? inst_q[rd_ptr] : '0;
    assign out_pc = out_valid ? pc_q[rd_ptr] : '0;
    assign push = pend & ~kill & ~redirect_i;
    assign pop = out_valid & out_ready & ~redirect_i;
    assign unused = ^redirect_pc_i[1:0];

`ifdef IFQ_JUMP_PREDECODE_EN
    logic signed [26:0] jump_off;
    assign jump_off = {imem_rdata_i[31:7], 2'b00};
    assign jump = push & (imem_rdata_i[6:0] == 7'b1100011);
    assign next_pc = jump ? pend_pc + XLEN'(4) + XLEN'(jump_off) : fetch_pc + XLEN'(4);
`else
    assign jump = 1'b0;
    assign next_pc = fetch_pc + XLEN'(4);
`endif

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            fetch_pc <= RESET_PC;
            pend     <= 1'b0;
            pend_pc  <= '0;
            kill     <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            pend <= imem_req_o;
            if (imem_req_o) pend_pc <= fetch_pc;
            if (redirect_i) begin
                fetch_pc <= {redirect_pc_i[XLEN-1:2], 2'b00};
                kill     <= 1'b0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                count    <= '0;
            end else begin
                if (imem_req_o | jump) fetch_pc <= next_pc;
                // A kill is only armed when a sequential word is actually in flight behind the jump.
                kill <= jump ? imem_req_o : kill & ~pend;
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop) rd_ptr <= rd_ptr + AW'(1);
                count <= count + (AW+1)'(push) - (AW+1)'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            inst_q[wr_ptr] <= imem_rdata_i;
            pc_q[wr_ptr]   <= pend_pc;
        end
    end
endmodule

// File: tb/tb_ifq_fetch_unit.sv
// tb_ifq_fetch_unit: randomized scenario bench; expected pops come from a program-flow model of memory.
module tb_ifq_fetch_unit;
    localparam int DEPTH = 4;
`ifdef IFQ_JUMP_PREDECODE_EN
    localparam bit PD = 1'b1;
`else
    localparam bit PD = 1'b0;
`endif
    logic clk = 0, res = 0, req, redir = 0, rdy = 0, valid;
    logic [31:0] addr, rdata, redir_pc = 0, inst, opc;
    logic [$clog2(DEPTH):0] cnt;
    int n_cmp = 0, n_bad = 0, pops = 0;
    logic jw = 0, prev_req = 0;
    logic [31:0] exp_pc = 0;

    always #5 clk = ~clk;

    ifq_fetch_unit #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk(clk), .res(res), .imem_req_o(req), .imem_addr_o(addr), .imem_rdata_i(rdata),
        .redirect_i(redir), .redirect_pc_i(redir_pc), .out_valid(valid), .out_ready(rdy),
        .out_inst(inst), .out_pc(opc), .count(cnt)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (jw && a == 32'h34) ? 32'h000000E3 : {2'b00, a[31:2]};
    endfunction

    // Next instruction in program order: sequential, or the jump target when predecode is built in.
    function automatic logic [31:0] model_next(input logic [31:0] p);
`ifdef IFQ_JUMP_PREDECODE_EN
        logic [31:0] w = mem_word(p);
        if (w[6:0] == 7'b1100011) return p + 32'd4 + {{5{w[31]}}, w[31:7], 2'b00};
`endif
        return p + 32'd4;
    endfunction

    always @(posedge clk) rdata <= req ? mem_word(addr) : 32'hDEADBEEF;

    task automatic tick(input logic r, input logic rd, input logic [31:0] rp);
        prev_req = req;
        @(negedge clk);
        rdy = r; redir = rd; redir_pc = rp;
        #1;
    endtask

    task automatic do_reset(input logic r);
        @(negedge clk);
        res = 0; rdy = 0; redir = 0; redir_pc = 0;
        repeat (2) @(negedge clk);
        res = 1; rdy = r; exp_pc = 0; pops = 0; prev_req = 0;
        #1;
    endtask

    task automatic test_reset;
        @(negedge clk);
        res = 0; rdy = 1; redir = 0;
        repeat (2) @(negedge clk);
        #1;
        n_cmp += 6;
        if (req !== 1'b0) begin n_bad++; $display("FAIL reset_req: got %b want 0", req); end
        if (addr !== 32'h0) begin n_bad++; $display("FAIL reset_addr: got %h want 0", addr); end
        if (valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", valid); end
        if (cnt !== '0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", cnt); end
        if (inst !== 32'h0) begin n_bad++; $display("FAIL reset_inst: got %h want 0", inst); end
        if (opc !== 32'h0) begin n_bad++; $display("FAIL reset_pc: got %h want 0", opc); end
    endtask

    task automatic test_stream;
        int first_req = -1, first_valid = -1;
        logic [31:0] exp_addr = 0;
        do_reset(1);
        for (int i = 0; i < 20; i++) begin
            if (i > 0) tick(1, 0, 0);
            if (req) begin
                if (first_req < 0) first_req = i;
                n_cmp++;
                if (addr !== exp_addr) begin n_bad++; $display("FAIL stream_addr: got %h want %h", addr, exp_addr); end
                exp_addr += 4;
            end
            if (valid && first_valid < 0) first_valid = i;
            if (valid && rdy && !redir) begin
                n_cmp++;
                if (opc !== exp_pc || inst !== mem_word(exp_pc)) begin
                    n_bad++; $display("FAIL stream_pop: got pc=%h inst=%h want pc=%h inst=%h", opc, inst, exp_pc, mem_word(exp_pc));
                end
                exp_pc = model_next(exp_pc); pops++;
            end
        end
        n_cmp += 3;
        if (first_valid - first_req != 2) begin n_bad++; $display("FAIL stream_latency: got %0d want 2", first_valid - first_req); end
        if (pops != 18) begin n_bad++; $display("FAIL stream_rate: got %0d pops want 18", pops); end
        if (exp_addr !== 32'd80) begin n_bad++; $display("FAIL stream_reqs: got next addr %h want 50", exp_addr); end
    endtask

    task automatic test_backpressure;
        int nreq = 0;
        do_reset(0);
        for (int i = 0; i < 10; i++) begin
            if (i > 0) tick(0, 0, 0);
            if (req) nreq++;
        end
        n_cmp += 4;
        if (nreq != 4) begin n_bad++; $display("FAIL bp_reqs: got %0d want 4", nreq); end
        if (cnt !== 3'd4) begin n_bad++; $display("FAIL bp_count: got %0d want 4", cnt); end
        if (valid !== 1'b1) begin n_bad++; $display("FAIL bp_valid: got %b want 1", valid); end
        if (req !== 1'b0) begin n_bad++; $display("FAIL bp_req: got %b want 0", req); end
        for (int i = 0; i < 8; i++) begin
            tick(1, 0, 0);
            if (valid && rdy && !redir) begin
                n_cmp++;
                if (opc !== exp_pc || inst !== mem_word(exp_pc)) begin
                    n_bad++; $display("FAIL bp_pop: got pc=%h inst=%h want pc=%h", opc, inst, exp_pc);
                end
                exp_pc = model_next(exp_pc); pops++;
            end
        end
        n_cmp++;
        if (pops != 8) begin n_bad++; $display("FAIL bp_drain: got %0d pops want 8", pops); end
    endtask

    task automatic test_redirect;
        int n = 0;
        do_reset(0);
        while (!(cnt == 3 && prev_req) && n < 20) begin tick(0, 0, 0); n++; end
        n_cmp++;
        if (n >= 20) begin n_bad++; $display("FAIL redir_setup: count=%0d never reached 3 with pend", cnt); end
        tick(0, 1, 32'h43);
        exp_pc = 32'h40; pops = 0;
        n_cmp++;
        if (req !== 1'b0) begin n_bad++; $display("FAIL redir_req_t: got %b want 0", req); end
        tick(0, 0, 0);
        n_cmp += 4;
        if (cnt !== '0) begin n_bad++; $display("FAIL redir_flush: got %0d want 0", cnt); end
        if (req !== 1'b1) begin n_bad++; $display("FAIL redir_req_t1: got %b want 1", req); end
        if (addr !== 32'h40) begin n_bad++; $display("FAIL redir_addr: got %h want 40", addr); end
        if (valid !== 1'b0) begin n_bad++; $display("FAIL redir_valid_t1: got %b want 0", valid); end
        tick(0, 0, 0);
        n_cmp++;
        if (valid !== 1'b0) begin n_bad++; $display("FAIL redir_valid_t2: got %b want 0", valid); end
        tick(1, 0, 0);
        n_cmp += 2;
        if (valid !== 1'b1) begin n_bad++; $display("FAIL redir_valid_t3: got %b want 1", valid); end
        if (opc !== 32'h40) begin n_bad++; $display("FAIL redir_first_pc: got %h want 40", opc); end
        for (int i = 0; i < 10; i++) begin
            if (i > 0) tick(1, 0, 0);
            if (valid && rdy && !redir) begin
                n_cmp++;
                if (opc !== exp_pc || inst !== mem_word(exp_pc)) begin
                    n_bad++; $display("FAIL redir_pop: got pc=%h inst=%h want pc=%h", opc, inst, exp_pc);
                end
                exp_pc = model_next(exp_pc); pops++;
            end
        end
    endtask

    task automatic test_wrap;
        int n = 0;
        logic saw0 = 0;
        tick(0, 1, 32'hFFFFFFF0);
        exp_pc = 32'hFFFFFFF0; pops = 0;
        tick(0, 0, 0);
        while (!(cnt == 2 && prev_req && req) && n < 20) begin tick(0, 0, 0); n++; end
        tick(1, 0, 0);
        n_cmp++;
        if (cnt !== 3'd3 || !prev_req) begin n_bad++; $display("FAIL wrap_setup: count=%0d pend=%b want 3/1", cnt, prev_req); end
        for (int i = 0; i < 30; i++) begin
            if (i > 0) tick($urandom_range(0, 3) != 0, 0, 0);
            if (i == 1) begin
                n_cmp++;
                if (cnt !== 3'd3) begin n_bad++; $display("FAIL wrap_pushpop: got count %0d want 3", cnt); end
            end
            n_cmp++;
            if (cnt > DEPTH) begin n_bad++; $display("FAIL wrap_overflow: got count %0d want <= %0d", cnt, DEPTH); end
            if (valid && rdy && !redir) begin
                n_cmp++;
                if (opc !== exp_pc || inst !== mem_word(exp_pc)) begin
                    n_bad++; $display("FAIL wrap_pop: got pc=%h inst=%h want pc=%h", opc, inst, exp_pc);
                end
                if (opc === 32'h0) saw0 = 1;
                exp_pc = model_next(exp_pc); pops++;
            end
        end
        n_cmp++;
        if (saw0 !== 1'b1) begin n_bad++; $display("FAIL wrap_zero: got %b want 1 (pc 0 after FFFFFFFC)", saw0); end
    endtask

    task automatic test_random;
        int npop = 0;
        for (int i = 0; i < 300; i++) begin
            logic rd = ($urandom_range(0, 15) == 0);
            logic [31:0] rp = $urandom;
            tick($urandom_range(0, 2) != 0, rd, rp);
            n_cmp++;
            if (int'(cnt) + int'(prev_req) > DEPTH || (req && int'(cnt) + int'(prev_req) >= DEPTH)) begin
                n_bad++; $display("FAIL rand_credit: count=%0d pend=%b req=%b exceeds %0d", cnt, prev_req, req, DEPTH);
            end
            if (rd) exp_pc = {rp[31:2], 2'b00};
            else if (valid && rdy) begin
                n_cmp++;
                if (opc !== exp_pc || inst !== mem_word(exp_pc)) begin
                    n_bad++; $display("FAIL rand_pop: got pc=%h inst=%h want pc=%h inst=%h", opc, inst, exp_pc, mem_word(exp_pc));
                end
                exp_pc = model_next(exp_pc); npop++;
            end
        end
        n_cmp++;
        if (npop < 50) begin n_bad++; $display("FAIL rand_progress: got %0d pops want >= 50", npop); end
    endtask

    task automatic test_jump;
        logic saw38 = 0, saw3c = 0;
        jw = 1;
        do_reset(1);
        for (int i = 0; i < 30; i++) begin
            if (i > 0) tick(1, 0, 0);
            if (valid && rdy && !redir) begin
                n_cmp++;
                if (opc !== exp_pc || inst !== mem_word(exp_pc)) begin
                    n_bad++; $display("FAIL jump_pop: got pc=%h inst=%h want pc=%h inst=%h", opc, inst, exp_pc, mem_word(exp_pc));
                end
                if (opc === 32'h38) saw38 = 1;
                if (opc === 32'h3C) saw3c = 1;
                exp_pc = model_next(exp_pc);
            end
        end
        n_cmp += 2;
        if (saw38 !== !PD) begin n_bad++; $display("FAIL jump_skip38: got seen=%b want %b", saw38, !PD); end
        if (saw3c !== 1'b1) begin n_bad++; $display("FAIL jump_3c: got seen=%b want 1", saw3c); end
        jw = 0;
    endtask

    task automatic test_async_reset;
        int n = 0;
        do_reset(0);
        tick(0, 1, 32'h100);
        while (cnt != 2 && n < 20) begin tick(0, 0, 0); n++; end
        n_cmp++;
        if (opc !== 32'h100 || cnt !== 3'd2) begin n_bad++; $display("FAIL areset_setup: got pc=%h count=%0d want 100/2", opc, cnt); end
        #2 res = 0;
        #1;
        n_cmp += 5;
        if (valid !== 1'b0) begin n_bad++; $display("FAIL areset_valid: got %b want 0", valid); end
        if (cnt !== '0) begin n_bad++; $display("FAIL areset_count: got %0d want 0", cnt); end
        if (opc !== 32'h0) begin n_bad++; $display("FAIL areset_pc: got %h want 0", opc); end
        if (inst !== 32'h0) begin n_bad++; $display("FAIL areset_inst: got %h want 0", inst); end
        if (req !== 1'b0) begin n_bad++; $display("FAIL areset_req: got %b want 0", req); end
        @(negedge clk);
        @(negedge clk);
        res = 1; rdy = 1; exp_pc = 0; pops = 0;
        #1;
        n_cmp++;
        if (req !== 1'b1 || addr !== 32'h0) begin n_bad++; $display("FAIL areset_restart: got req=%b addr=%h want 1/0", req, addr); end
        for (int i = 0; i < 10; i++) begin
            if (i > 0) tick(1, 0, 0);
            if (valid && rdy && !redir) begin
                n_cmp++;
                if (opc !== exp_pc || inst !== mem_word(exp_pc)) begin
                    n_bad++; $display("FAIL areset_pop: got pc=%h inst=%h want pc=%h", opc, inst, exp_pc);
                end
                exp_pc = model_next(exp_pc); pops++;
            end
        end
        n_cmp++;
        if (pops != 8) begin n_bad++; $display("FAIL areset_rate: got %0d pops want 8", pops); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_wrap();
        test_random();
        test_jump();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
